// File: rtl/async_fifo_pkg.sv
// Shared constants and types for the single-clock FIFO.
// Holds the parameter defaults, the derived address width and the status bundle.
package async_fifo_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int FIFO_DEPTH_DEF = 8;
  localparam int ADDR_WIDTH_DEF = $clog2(FIFO_DEPTH_DEF);

  typedef struct packed {
    logic valid;
    logic overflow;
    logic underflow;
  } fifo_status_t;

  function automatic int addr_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: synchronous write port and registered read port.
// The read register clears on reset and holds its value when no read happens.
module fifo_mem
  import async_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = FIFO_DEPTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] rdata_d;

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re_i) begin
      rdata_d = mem_q[raddr_i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/async_fifo.sv
// Single-clock FIFO with wrap-bit pointers and one-cycle read latency.
// Overflow and underflow are registered one-cycle strobes.
module async_fifo
  import async_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_en,
  input  logic                  wr_en,
  output logic [DATA_WIDTH-1:0] rdata,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  valid,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int AW = addr_width(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]  wptr_q;
  logic [AW:0]  wptr_d;
  logic [AW:0]  rptr_q;
  logic [AW:0]  rptr_d;
  logic         wr_acc;
  logic         rd_acc;
  fifo_status_t stat_q;
  fifo_status_t stat_d;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) &&
                 (wptr_q[AW] != rptr_q[AW]);

  // Acceptance uses the pre-edge flags, so read and write never conflict.
  always_comb begin
    wr_acc = wr_en & ~full;
    rd_acc = rd_en & ~empty;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (wr_acc) begin
      wptr_d = wptr_q + PTR_ONE;
    end
    if (rd_acc) begin
      rptr_d = rptr_q + PTR_ONE;
    end
    stat_d.valid     = rd_acc;
    stat_d.overflow  = wr_en & full;
    stat_d.underflow = rd_en & empty;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      stat_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      stat_q <= stat_d;
    end
  end

  assign valid     = stat_q.valid;
  assign overflow  = stat_q.overflow;
  assign underflow = stat_q.underflow;

  // Enables are masked with rst so unknown requests during reset are inert.
  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH),
    .ADDR_WIDTH (AW)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .we_i    (wr_acc & ~rst),
    .waddr_i (wptr_q[AW-1:0]),
    .wdata_i (wdata),
    .re_i    (rd_acc & ~rst),
    .raddr_i (rptr_q[AW-1:0]),
    .rdata_o (rdata)
  );

endmodule

// File: tb/tb_async_fifo.sv
// Scoreboard bench for async_fifo against a queue-based reference model.
// Directed scenarios first, then randomized traffic with occasional resets.
module tb_async_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 8;

  bit            clk;
  logic          rst;
  logic          rd_en;
  logic          wr_en;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          valid;
  logic          empty;
  logic          full;
  logic          overflow;
  logic          underflow;

  typedef struct {
    logic          vld;
    logic          ovf;
    logic          udf;
    logic [DW-1:0] rd;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] model_q[$];
  logic [DW-1:0] last_rd;
  int            vectors;
  int            miscompares;

  always #5 clk = ~clk;

  async_fifo #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rd_en     (rd_en),
    .wr_en     (wr_en),
    .rdata     (rdata),
    .wdata     (wdata),
    .valid     (valid),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("valid", 32'(valid), 32'(e.vld));
      chk("overflow", 32'(overflow), 32'(e.ovf));
      chk("underflow", 32'(underflow), 32'(e.udf));
      chk("rdata", 32'(rdata), 32'(e.rd));
    end
  end

  task automatic step(input logic wr, input logic rd, input logic [DW-1:0] d);
    bit   fm;
    bit   em;
    exp_t e;
    fm = (model_q.size() == DEPTH);
    em = (model_q.size() == 0);
    chk("empty", 32'(empty), 32'(em));
    chk("full", 32'(full), 32'(fm));
    rst   = 1'b0;
    wr_en = wr;
    rd_en = rd;
    wdata = d;
    e.vld = rd && !em;
    e.ovf = wr && fm;
    e.udf = rd && em;
    if (rd && !em) last_rd = model_q.pop_front();
    if (wr && !fm) model_q.push_back(d);
    e.rd = last_rd;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic do_reset();
    exp_t e;
    rst   = 1'b1;
    wr_en = 1'bx;
    rd_en = 1'bx;
    wdata = 'x;
    model_q.delete();
    last_rd = '0;
    e.vld = 1'b0;
    e.ovf = 1'b0;
    e.udf = 1'b0;
    e.rd  = '0;
    exp_q.push_back(e);
    @(negedge clk);
    rst   = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    rst   = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    wdata = '0;
    vectors     = 0;
    miscompares = 0;
    last_rd     = '0;
    do_reset();

    for (int k = 0; k < 12; k++) step(1'b1, 1'b0, DW'(k));
    for (int k = 0; k < 10; k++) step(1'b0, 1'b1, '0);

    for (int t = 0; t < 22; t++)
      step(t < 20, t >= 2, DW'(100 + t));

    for (int k = 0; k < DEPTH; k++) step(1'b1, 1'b0, DW'(8'h30 + k));
    step(1'b1, 1'b1, 8'hEE);
    for (int k = 0; k < DEPTH; k++) step(1'b0, 1'b1, '0);
    step(1'b1, 1'b1, 8'h5C);
    step(1'b0, 1'b1, '0);

    for (int k = 0; k < 5; k++) step(1'b1, 1'b0, DW'(8'h60 + k));
    do_reset();
    step(1'b1, 1'b0, 8'hA5);
    step(1'b0, 1'b1, '0);
    step(1'b0, 1'b0, '0);

    for (int ph = 0; ph < 4; ph++) begin
      for (int n = 0; n < 120; n++) begin
        if ($urandom_range(0, 59) == 0) begin
          do_reset();
        end else begin
          step($urandom_range(0, 99) < (ph[0] ? 35 : 70),
               $urandom_range(0, 99) < (ph[0] ? 70 : 35),
               DW'($urandom));
        end
      end
    end

    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    @(negedge clk);
    chk("drain", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/async_fifo.md
ASYNC_FIFO -- requirements
Module: async_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of wdata/rdata.
REQ-002 Parameter FIFO_DEPTH, default 8, number of entries; SHALL be a power of two and at least 2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 rd_en  input  1  read request.
REQ-006 wr_en  input  1  write request.
REQ-007 rdata  output  DATA_WIDTH  registered read data.
REQ-008 wdata  input  DATA_WIDTH  write data.
REQ-009 valid  output  1  one-cycle strobe: rdata holds a newly popped word.
REQ-010 empty  output  1  no stored entries.
REQ-011 full  output  1  FIFO_DEPTH stored entries.
REQ-012 overflow  output  1  one-cycle strobe: write rejected because full.
REQ-013 underflow  output  1  one-cycle strobe: read rejected because empty.
REQ-014 Port order SHALL be clk, rst, rd_en, wr_en, rdata, wdata, valid, empty, full, overflow, underflow; one clock, reset synchronous and active-high.

Function
REQ-015 Write pointer and read pointer SHALL each be log2(FIFO_DEPTH)+1 bits; the low bits address storage, the MSB is the wrap bit.
REQ-016 empty SHALL be combinational: 1 when both pointers are equal, including the wrap bit.
REQ-017 full SHALL be combinational: 1 when the address bits are equal and the wrap bits differ.
REQ-018 Accepted write = wr_en and not full: store wdata at the write address, then increment the write pointer modulo 2^(ADDR+1).
REQ-019 Accepted read = rd_en and not empty: on the same edge, load rdata with the entry at the read address, set valid=1, and increment the read pointer.
REQ-020 Read latency SHALL be one clock: rdata/valid change on the edge that samples rd_en.
REQ-021 valid SHALL be 0 in any cycle with no accepted read; rdata SHALL hold its last value.
REQ-022 overflow SHALL be 1 for the cycle after an edge where wr_en=1 and full=1, and 0 otherwise; a rejected write SHALL leave memory and pointers unchanged.
REQ-023 underflow SHALL be 1 for the cycle after an edge where rd_en=1 and empty=1, and 0 otherwise; a rejected read SHALL leave the read pointer, rdata and valid=0 unchanged.
REQ-024 Acceptance of simultaneous read and write SHALL be decided from the pre-edge flags.
  - While full: the read is accepted and the write is rejected with overflow.
  - While empty: the write is accepted and the read is rejected with underflow.
  - Otherwise: both are accepted and the occupancy is unchanged.
REQ-025 Pointer wrap SHALL be seamless; data order is strict FIFO across any number of wraps.
REQ-026 X on wr_en/rd_en while rst=1 SHALL have no effect.

Reset
REQ-027 On a clk edge with rst=1, both pointers SHALL be set to 0 and the outputs SHALL be rdata=0, valid=0, overflow=0, underflow=0.
REQ-028 After reset, empty=1 and full=0; storage contents are not reset and are never observable before being written.
REQ-029 Reset SHALL override any simultaneous rd_en/wr_en; mid-operation reset discards all stored entries.

Structure
REQ-030 DATA_WIDTH/FIFO_DEPTH defaults and the derived address width constant SHALL reside in shared package async_fifo_pkg.
REQ-031 Storage SHALL be one sub-module fifo_mem: a DEPTH x DATA_WIDTH array with synchronous write port and read port; pointer/flag logic stays in async_fifo.

Verification
REQ-032 Reset, then write k=0..11 on 12 consecutive cycles with rd_en=0 -> full=1 after the 8th write; overflow pulses on writes 9-12; entries hold 0..7.
REQ-033 From the full state, hold rd_en=1 for 10 cycles -> valid pulses 8 times with rdata 0,1,...,7; empty=1 after the 8th read; underflow pulses on reads 9-10 with valid=0.
REQ-034 Stream 20 words (values 100..119) with one read per cycle lagging two cycles behind the writes -> the output order is exactly 100..119, the pointers wrap twice, and neither overflow nor underflow pulses.
REQ-035 Simultaneous events:
  - Full with wr_en=rd_en=1 -> one pop, write rejected, overflow=1, full drops to 0.
  - Empty with wr_en=rd_en=1 -> underflow=1, one entry stored, empty=0.
REQ-036 Write 5 words, assert rst for one cycle mid-stream -> empty=1, full=0, valid=0, rdata=0; a subsequent write/read of 0xA5 returns 0xA5.
